// File: rtl/store_commit_buffer.sv
// Write-through store queue: holds speculative stores until commit, then issues
// committed stores to the dcache in order with a cap on in-flight writes.
module store_commit_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 7
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 st_valid_i,
  output logic                                 st_ready_o,
  input  logic [ADDR_W-1:0]                    st_addr_i,
  input  logic [DATA_W-1:0]                    st_data_i,
  input  logic [DATA_W/8-1:0]                  st_be_i,
  input  logic                                 commit_i,
  output logic                                 req_valid_o,
  input  logic                                 req_ready_i,
  output logic [ADDR_W-1:0]                    req_addr_o,
  output logic [DATA_W-1:0]                    req_data_o,
  output logic [DATA_W/8-1:0]                  req_be_o,
  input  logic                                 ack_i,
  output logic                                 empty_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = DATA_W / 8;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BW-1:0]     be_q   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] total_cnt_q, total_cnt_d;
  logic [CW-1:0] commit_cnt_q, commit_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;

  logic push, commit, issue, ack;

  // Handshake qualification uses only registered counts, so a store pushed
  // this cycle cannot be committed until the next one.
  always_comb begin
    st_ready_o  = (total_cnt_q < CW'(DEPTH)) && !flush_i;
    push        = st_valid_i && st_ready_o;
    commit      = commit_i && (total_cnt_q != commit_cnt_q);
    req_valid_o = (commit_cnt_q != '0) && (out_cnt_q < OW'(MAX_OUTSTANDING));
    issue       = req_valid_o && req_ready_i;
    ack         = ack_i && (out_cnt_q != '0);
  end

  always_comb begin
    commit_ptr_d = commit_ptr_q + PW'(commit);
    rd_ptr_d     = rd_ptr_q + PW'(issue);
    commit_cnt_d = commit_cnt_q + CW'(commit) - CW'(issue);
    out_cnt_d    = out_cnt_q + OW'(issue) - OW'(ack);
    wr_ptr_d     = wr_ptr_q + PW'(push);
    total_cnt_d  = total_cnt_q + CW'(push) - CW'(issue);
    // Flush drops everything past the commit point, keeping a same-cycle commit.
    if (flush_i) begin
      wr_ptr_d    = commit_ptr_d;
      total_cnt_d = commit_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      total_cnt_q  <= '0;
      commit_cnt_q <= '0;
      out_cnt_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      total_cnt_q  <= total_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= st_addr_i;
      data_q[wr_ptr_q] <= st_data_i;
      be_q[wr_ptr_q]   <= st_be_i;
    end
  end

  assign req_addr_o    = addr_q[rd_ptr_q];
  assign req_data_o    = data_q[rd_ptr_q];
  assign req_be_o      = be_q[rd_ptr_q];
  assign empty_o       = (total_cnt_q == '0) && (out_cnt_q == '0);
  assign outstanding_o = out_cnt_q;

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(commit_i && (total_cnt_q == commit_cnt_q)))
        else $warning("store_commit_buffer: commit with no uncommitted store ignored");
      assert (!(ack_i && (out_cnt_q == '0)))
        else $warning("store_commit_buffer: ack with no outstanding write ignored");
    end
  end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer (DEPTH=4, MAX_OUTSTANDING=7).
module tb_store_commit_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        st_valid_i;
  logic        st_ready_o;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_be_i;
  logic        commit_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic [31:0] req_data_o;
  logic [3:0]  req_be_o;
  logic        ack_i;
  logic        empty_o;
  logic [2:0]  outstanding_o;

  int n_tests = 0;
  int n_fail  = 0;

  store_commit_buffer #(
    .DEPTH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(7)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .commit_i(commit_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_data_o(req_data_o), .req_be_o(req_be_o),
    .ack_i(ack_i), .empty_o(empty_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input string tag);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = d;
    st_be_i    = 4'hF;
    #1;
    chk1(tag, st_ready_o, 1'b1);
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk1({tag, "_valid"}, req_valid_o, 1'b1);
    chk({tag, "_addr"}, req_addr_o, a);
    chk({tag, "_data"}, req_data_o, d);
    chk({tag, "_be"}, 32'(req_be_o), 32'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; st_valid_i = 1'b0; st_addr_i = '0;
    st_data_i = '0; st_be_i = '0; commit_i = 1'b0; req_ready_i = 1'b0; ack_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    #1;
    chk1("rst_ready", st_ready_o, 1'b1);
    chk1("rst_reqv", req_valid_o, 1'b0);
    chk1("rst_empty", empty_o, 1'b1);
    chk("rst_out", 32'(outstanding_o), 0);

    // Uncommitted stores never issue; committed ones issue in order.
    push(32'h8000_0000, 32'h11, "t1_push0");
    push(32'h8000_0004, 32'h22, "t1_push1");
    push(32'h8000_0008, 32'h33, "t1_push2");
    for (int i = 0; i < 10; i++) begin
      chk1("t1_noreq", req_valid_o, 1'b0);
      tick();
    end
    commit_i = 1'b1; req_ready_i = 1'b1;
    #1;
    chk1("t1_noreq_commit_cycle", req_valid_o, 1'b0);
    tick();
    chk_req("t1_req0", 32'h8000_0000, 32'h11);
    tick();
    commit_i = 1'b0;
    #1;
    chk_req("t1_req1", 32'h8000_0004, 32'h22);
    tick();
    req_ready_i = 1'b0;
    #1;
    chk1("t1_third_held", req_valid_o, 1'b0);
    chk1("t1_empty", empty_o, 1'b0);
    chk("t1_out", 32'(outstanding_o), 2);

    // Drain acks, then an ack with nothing outstanding must not underflow.
    ack_i = 1'b1;
    tick(); tick();
    ack_i = 1'b0;
    #1;
    chk("t5_out_drained", 32'(outstanding_o), 0);
    chk1("t5_empty_queued", empty_o, 1'b0);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    #1;
    chk("t5_spurious_ack", 32'(outstanding_o), 0);

    // Fill to DEPTH (with pointer wrap), refuse the extra push, accept after a handshake.
    push(32'h8000_0010, 32'h44, "t2_push_b0");
    push(32'h8000_0014, 32'h55, "t2_push_b1");
    push(32'h8000_0018, 32'h66, "t2_push_b2");
    st_valid_i = 1'b1; st_addr_i = 32'h8000_001C; st_data_i = 32'h77; st_be_i = 4'hF;
    #1;
    chk1("t2_full_refuse", st_ready_o, 1'b0);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; req_ready_i = 1'b1;
    #1;
    chk1("t2_full_still", st_ready_o, 1'b0);
    chk_req("t2_req_a2", 32'h8000_0008, 32'h33);
    tick();
    chk1("t2_ready_after_issue", st_ready_o, 1'b1);
    tick();
    st_valid_i = 1'b0; req_ready_i = 1'b0;
    #1;
    chk1("t2_full_again", st_ready_o, 1'b0);
    chk1("t2_no_committed", req_valid_o, 1'b0);

    // Flush with a same-cycle commit: the committed store survives, the push is refused.
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; req_ready_i = 1'b1;
    #1;
    chk_req("t4_req_b0", 32'h8000_0010, 32'h44);
    tick();
    req_ready_i = 1'b0;
    commit_i = 1'b1; flush_i = 1'b1;
    st_valid_i = 1'b1; st_addr_i = 32'h8000_0020; st_data_i = 32'hFF;
    #1;
    chk1("t4_flush_refuse", st_ready_o, 1'b0);
    tick();
    commit_i = 1'b0; flush_i = 1'b0; st_valid_i = 1'b0;
    #1;
    chk1("t4_ready_after_flush", st_ready_o, 1'b1);
    chk("t4_out_kept", 32'(outstanding_o), 2);
    push(32'h8000_0020, 32'h99, "t4_push_d");
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; req_ready_i = 1'b1;
    #1;
    chk_req("t4_req_b1", 32'h8000_0014, 32'h55);
    tick();
    chk_req("t4_req_d", 32'h8000_0020, 32'h99);
    tick();
    req_ready_i = 1'b0;
    #1;
    chk1("t4_drained", req_valid_o, 1'b0);
    chk("t4_out", 32'(outstanding_o), 4);

    // Ack and issue in the same cycle leave the in-flight count unchanged.
    push(32'h8000_0024, 32'hAA, "t5_push_e");
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; req_ready_i = 1'b1; ack_i = 1'b1;
    #1;
    chk_req("t5_req_e", 32'h8000_0024, 32'hAA);
    chk("t5_out_before", 32'(outstanding_o), 4);
    tick();
    req_ready_i = 1'b0; ack_i = 1'b0;
    #1;
    chk("t5_out_after", 32'(outstanding_o), 4);

    // Outstanding cap: issue stalls at 7 until an ack frees a slot.
    push(32'h8000_0028, 32'hBB, "t3_push_f0");
    push(32'h8000_002C, 32'hCC, "t3_push_f1");
    push(32'h8000_0030, 32'hDD, "t3_push_f2");
    commit_i = 1'b1;
    tick(); tick(); tick();
    commit_i = 1'b0;
    push(32'h8000_0034, 32'hEE, "t3_push_f3");
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; req_ready_i = 1'b1;
    #1;
    chk_req("t3_req_f0", 32'h8000_0028, 32'hBB);
    tick(); tick(); tick();
    chk("t3_out_cap", 32'(outstanding_o), 7);
    chk1("t3_stall", req_valid_o, 1'b0);
    tick();
    chk1("t3_stall_hold", req_valid_o, 1'b0);
    chk("t3_out_hold", 32'(outstanding_o), 7);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    #1;
    chk("t3_out_after_ack", 32'(outstanding_o), 6);
    chk_req("t3_req_f3", 32'h8000_0034, 32'hEE);
    tick();
    req_ready_i = 1'b0;
    #1;
    chk("t3_out_recap", 32'(outstanding_o), 7);
    chk1("t3_empty", empty_o, 1'b0);

    // Mid-run reset clears queue and in-flight count.
    push(32'h8000_0050, 32'h01, "t6_push0");
    push(32'h8000_0054, 32'h02, "t6_push1");
    push(32'h8000_0058, 32'h03, "t6_push2");
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    chk1("t6_ready", st_ready_o, 1'b1);
    chk1("t6_reqv", req_valid_o, 1'b0);
    chk1("t6_empty", empty_o, 1'b1);
    chk("t6_out", 32'(outstanding_o), 0);
    push(32'h8000_0040, 32'h12, "t6_push_g");
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    #1;
    chk_req("t6_req_g", 32'h8000_0040, 32'h12);
    chk1("t6_not_empty", empty_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
